tx_fir: RTL and testbench

TX_FIR -- requirements
Module: tx_fir

---
 rtl/tx_fir_pkg.sv | 35 +++
 rtl/tx_fir_if.sv | 24 ++
 rtl/tx_fir_mac.sv | 69 ++++++
 rtl/tx_fir.sv | 128 ++++++++++++
 tb/tb_tx_fir.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_fir_pkg.sv
// Shared widths, FSM state type and the symmetric Q1.14 prototype
// coefficient table for the 2x interpolating TX FIR.
package tx_fir_pkg;

    localparam int DIN_W   = 16;
    localparam int COEF_W  = 16;
    localparam int DOUT_W  = 18;
    localparam int ACC_W   = 36;
    localparam int NTAPS_C = 32;
    localparam int FRAC    = 14;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC0,
        OUT0,
        MAC1,
        OUT1
    } state_t;

    typedef logic signed [COEF_W-1:0] coef_t;

    // h[k] == h[31-k]; even indices feed phase 0, odd indices phase 1
    localparam coef_t COEFS [NTAPS_C] = '{
        -16'sd120,   -16'sd250,   16'sd180,    16'sd420,
        -16'sd300,   -16'sd700,   16'sd500,    16'sd1100,
        -16'sd800,   -16'sd1700,  16'sd1300,   16'sd2700,
        -16'sd2200,  16'sd12000,  16'sd20000,  16'sd32000,
        16'sd32000,  16'sd20000,  16'sd12000,  -16'sd2200,
        16'sd2700,   16'sd1300,   -16'sd1700,  -16'sd800,
        16'sd1100,   16'sd500,    -16'sd700,   -16'sd300,
        16'sd420,    16'sd180,    -16'sd250,   -16'sd120
    };

endpackage

// File: rtl/tx_fir_if.sv
// Sample-in / sample-out handshake bundle of the TX FIR.
interface tx_fir_if;
    import tx_fir_pkg::*;

    logic                     nd;
    logic signed [DIN_W-1:0]  din;
    logic                     chan_in;
    logic                     rfd;
    logic                     rdy;
    logic signed [DOUT_W-1:0] dout;
    logic                     chan_out;
    logic                     ovf;

    modport slave (
        input  nd, din, chan_in,
        output rfd, rdy, dout, chan_out, ovf
    );

    modport master (
        output nd, din, chan_in,
        input  rfd, rdy, dout, chan_out, ovf
    );

endinterface

// File: rtl/tx_fir_mac.sv
// Serial signed multiply-accumulate with round-half-up Q1.14 rescale and
// 18-bit saturation; dout register loads on the final product of a phase.
module tx_fir_mac
    import tx_fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     sclr,
    input  logic                     acc_clr_i,
    input  logic                     mac_en_i,
    input  logic                     out_ld_i,
    input  logic signed [DIN_W-1:0]  samp_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [DOUT_W-1:0] dout_o
);

    localparam int RW = ACC_W - FRAC;
    localparam logic signed [ACC_W-1:0]  RND_C = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [DOUT_W-1:0] DMAX  = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic signed [DOUT_W-1:0] DMIN  = {1'b1, {(DOUT_W-1){1'b0}}};
    localparam logic signed [RW-1:0]     HI_C  = RW'(DMAX);
    localparam logic signed [RW-1:0]     LO_C  = RW'(DMIN);

    function automatic logic signed [RW-1:0] round_q14(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] t;
        t = a + RND_C;
        return t[ACC_W-1:FRAC];
    endfunction

    function automatic logic signed [DOUT_W-1:0] sat_out(input logic signed [RW-1:0] v);
        if (v > HI_C) begin
            return DMAX;
        end else if (v < LO_C) begin
            return DMIN;
        end
        return v[DOUT_W-1:0];
    endfunction

    logic signed [2*DIN_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic signed [DOUT_W-1:0]  dout_q;

    assign prod    = 32'(samp_i) * 32'(coef_i);
    assign acc_sum = acc_q + ACC_W'(prod);

    always_comb begin
        acc_d = acc_q;
        if (acc_clr_i) begin
            acc_d = '0;
        end else if (mac_en_i) begin
            acc_d = acc_sum;
        end
    end

    // acc_sum already holds the last tap, so dout is ready in the OUT cycle
    always_ff @(posedge clk) begin
        if (sclr) begin
            acc_q  <= '0;
            dout_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (out_ld_i) begin
                dout_q <= sat_out(round_q14(acc_sum));
            end
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/tx_fir.sv
// Two-channel, 32-tap interpolate-by-2 polyphase FIR: FSM sequencing, per
// channel 16-deep delay lines, and the shared serial MAC.
module tx_fir
    import tx_fir_pkg::*;
#(
    parameter int NTAPS = 32,
    parameter int L     = 2
) (
    input  logic     clk,
    input  logic     sclr,
    tx_fir_if.slave  bus
);

    localparam int TPP = NTAPS / L;

    state_t                  state_q, state_d;
    logic [3:0]              tap_q, tap_d;
    logic                    chan_q, chan_d;
    logic signed [DIN_W-1:0] samp_q, samp_d;
    logic signed [DIN_W-1:0] line_q [2][TPP];
    logic                    ovf_q;
    logic                    chan_out_q;
    logic                    acc_clr, mac_en, out_ld;
    logic                    phase;
    logic signed [DIN_W-1:0] mac_samp;
    coef_t                   mac_coef;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        chan_d  = chan_q;
        samp_d  = samp_q;
        acc_clr = 1'b0;
        mac_en  = 1'b0;
        out_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.nd) begin
                    state_d = LOAD;
                    chan_d  = bus.chan_in;
                    samp_d  = bus.din;
                end
            end
            LOAD: begin
                acc_clr = 1'b1;
                tap_d   = '0;
                state_d = MAC0;
            end
            MAC0, MAC1: begin
                mac_en = 1'b1;
                tap_d  = tap_q + 4'd1;
                if (tap_q == 4'd15) begin
                    out_ld  = 1'b1;
                    state_d = (state_q == MAC0) ? OUT0 : OUT1;
                end
            end
            OUT0: begin
                acc_clr = 1'b1;
                state_d = MAC1;
            end
            OUT1: begin
                acc_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q    <= IDLE;
            tap_q      <= '0;
            ovf_q      <= 1'b0;
            chan_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            if (bus.nd && (state_q != IDLE)) begin
                ovf_q <= 1'b1;
            end
            if (out_ld) begin
                chan_out_q <= chan_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        chan_q <= chan_d;
        samp_q <= samp_d;
    end

    // Only the latched channel's line shifts; newest sample sits at index 0
    always_ff @(posedge clk) begin
        if (sclr) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < TPP; i++) begin
                    line_q[c][i] <= '0;
                end
            end
        end else if (state_q == LOAD) begin
            line_q[chan_q][0] <= samp_q;
            for (int i = 1; i < TPP; i++) begin
                line_q[chan_q][i] <= line_q[chan_q][i-1];
            end
        end
    end

    assign phase    = (state_q == MAC1);
    assign mac_samp = line_q[chan_q][tap_q];
    assign mac_coef = COEFS[{tap_q, phase}];

    tx_fir_mac u_mac (
        .clk       (clk),
        .sclr      (sclr),
        .acc_clr_i (acc_clr),
        .mac_en_i  (mac_en),
        .out_ld_i  (out_ld),
        .samp_i    (mac_samp),
        .coef_i    (mac_coef),
        .dout_o    (bus.dout)
    );

    assign bus.rfd      = (state_q == IDLE);
    assign bus.rdy      = (state_q == OUT0) || (state_q == OUT1);
    assign bus.chan_out = chan_out_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_tx_fir.sv
// Bench for tx_fir: table-driven impulse/isolation vectors, a behavioural
// polyphase model for the rest, and a scoreboard popped on every rdy.
module tb_tx_fir;

    logic clk;
    logic sclr;

    tx_fir_if bus();

    tx_fir #(.NTAPS(32), .L(2)) dut (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int HH [16] = '{
        -120, -250, 180, 420, -300, -700, 500, 1100,
        -800, -1700, 1300, 2700, -2200, 12000, 20000, 32000
    };

    typedef struct {
        bit chan;
        int din;
        int exp0;
        int exp1;
    } vec_t;

    typedef struct {
        int d;
        bit c;
    } exp_t;

    vec_t tab_a [16];
    vec_t tab_b [32];
    exp_t sbq [$];
    exp_t mon_e;
    int   mline [2][16];
    int   n_chk;
    int   n_fail;
    bit   have_last;
    int   last_d;
    bit   last_c;

    function automatic int h(input int k);
        return (k < 16) ? HH[k] : HH[31-k];
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < 16; j++) begin
                mline[c][j] = 0;
            end
        end
    endtask

    task automatic model_accept(input bit ch, input int x, output int y0, output int y1);
        longint acc;
        longint r;
        for (int j = 15; j > 0; j--) begin
            mline[ch][j] = mline[ch][j-1];
        end
        mline[ch][0] = x;
        y0 = 0;
        y1 = 0;
        for (int p = 0; p < 2; p++) begin
            acc = 0;
            for (int j = 0; j < 16; j++) begin
                acc += longint'(h(2*j + p)) * longint'(mline[ch][j]);
            end
            r = (acc + 8192) >>> 14;
            if (r > 131071) r = 131071;
            else if (r < -131072) r = -131072;
            if (p == 0) y0 = int'(r);
            else y1 = int'(r);
        end
    endtask

    task automatic wait_rfd();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.rfd) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rfd_wait", ok, 1);
    endtask

    // Returns one cycle after nd was presented (cycle 1 of the transaction)
    task automatic send(input bit ch, input int x, input bit use_tab,
                        input int e0, input int e1, input bit push);
        int m0, m1;
        wait_rfd();
        bus.nd      = 1'b1;
        bus.din     = 16'(x);
        bus.chan_in = ch;
        model_accept(ch, x, m0, m1);
        if (push) begin
            sbq.push_back('{use_tab ? e0 : m0, ch});
            sbq.push_back('{use_tab ? e1 : m1, ch});
        end
        step();
        bus.nd = 1'b0;
    endtask

    task automatic wait_rdy(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (sclr) begin
            have_last = 1'b0;
        end else if (bus.rdy) begin
            if (sbq.size() == 0) begin
                chk("rdy_unexpected", bus.rdy, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("dout", bus.dout, mon_e.d);
                chk("chan_out", bus.chan_out, mon_e.c);
            end
            last_d    = bus.dout;
            last_c    = bus.chan_out;
            have_last = 1'b1;
        end else if (have_last) begin
            chk("dout_hold", bus.dout, last_d);
            chk("chan_hold", bus.chan_out, last_c);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int x;
        n_chk     = 0;
        n_fail    = 0;
        have_last = 1'b0;
        model_clear();

        for (int k = 0; k < 16; k++) begin
            tab_a[k]       = '{1'b0, (k == 0) ? 16384 : 0, h(2*k), h(2*k + 1)};
            tab_b[2*k]     = '{1'b1, (k == 0) ? 16384 : 0, h(2*k), h(2*k + 1)};
            tab_b[2*k + 1] = '{1'b0, 0, 0, 0};
        end

        sclr        = 1'b1;
        bus.nd      = 1'b0;
        bus.din     = '0;
        bus.chan_in = 1'b0;
        repeat (3) step();
        sclr = 1'b0;
        chk("rst_rfd", bus.rfd, 1);
        chk("rst_rdy", bus.rdy, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_chan_out", bus.chan_out, 0);
        chk("rst_ovf", bus.ovf, 0);

        // Impulse on channel 0
        for (int i = 0; i < 16; i++) begin
            send(tab_a[i].chan, tab_a[i].din, 1'b1, tab_a[i].exp0, tab_a[i].exp1, 1'b1);
            repeat (62) step();
        end

        // Channel isolation
        for (int i = 0; i < 32; i++) begin
            send(tab_b[i].chan, tab_b[i].din, 1'b1, tab_b[i].exp0, tab_b[i].exp1, 1'b1);
            repeat (62) step();
        end

        // Overrun: second nd at cycle 10 is dropped
        send(1'b0, 1000, 1'b0, 0, 0, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) step();
            if (c == 10) begin
                bus.nd      = 1'b1;
                bus.din     = 16'sd5000;
                bus.chan_in = 1'b1;
            end
            if (c == 11) bus.nd = 1'b0;
            chk("t_rdy", bus.rdy, (c == 18) || (c == 35));
            chk("t_ovf", bus.ovf, c >= 11);
            chk("t_rfd", bus.rfd, c >= 36);
        end

        // Reset in the middle of MAC0
        send(1'b1, 7000, 1'b0, 0, 0, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) step();
            if (c == 8) begin
                chk("r_ovf_before", bus.ovf, 1);
                sclr = 1'b1;
            end
            if (c == 9) begin
                sclr = 1'b0;
                chk("r_rfd", bus.rfd, 1);
                chk("r_ovf", bus.ovf, 0);
                chk("r_dout", bus.dout, 0);
                chk("r_chan_out", bus.chan_out, 0);
            end
            chk("r_rdy", bus.rdy, 0);
        end
        model_clear();

        for (int i = 0; i < 16; i++) begin
            send(tab_a[i].chan, tab_a[i].din, 1'b1, tab_a[i].exp0, tab_a[i].exp1, 1'b1);
            repeat (62) step();
        end

        // Positive saturation: sample signs aligned with phase-0 taps
        for (int i = 0; i < 16; i++) begin
            x = (h(2*(15 - i)) >= 0) ? 32767 : -32768;
            send(1'b0, x, 1'b0, 0, 0, 1'b1);
        end
        wait_rdy(60, ok);
        chk("sat_pos_rdy", ok, 1);
        chk("sat_pos", bus.dout, 131071);

        for (int i = 0; i < 16; i++) begin
            x = (h(2*(15 - i)) >= 0) ? -32768 : 32767;
            send(1'b0, x, 1'b0, 0, 0, 1'b1);
        end
        wait_rdy(60, ok);
        chk("sat_neg_rdy", ok, 1);
        chk("sat_neg", bus.dout, -131072);

        // nd together with sclr: reset wins, nothing is loaded
        wait_rfd();
        repeat (40) step();
        sclr        = 1'b1;
        bus.nd      = 1'b1;
        bus.din     = 16'sd16384;
        bus.chan_in = 1'b0;
        step();
        sclr   = 1'b0;
        bus.nd = 1'b0;
        chk("sclr_nd_rfd", bus.rfd, 1);
        model_clear();
        repeat (40) step();
        chk("sclr_nd_ovf", bus.ovf, 0);
        send(1'b0, 0, 1'b0, 0, 0, 1'b1);

        repeat (80) step();
        chk("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
